// File: rtl/mario_sprite_fetch.sv
// Mario sprite ROM read front end: raster hit test, mirrored ROM addressing,
// a 3-cycle pixel pipeline around the ROM, and the walk-animation frame selector.
module mario_sprite_fetch #(
   parameter int          SPRITE_W    = 16,
   parameter int          SPRITE_H    = 16,
   parameter int          NUM_FRAMES  = 5,
   parameter int          FRAME_TICKS = 6,
   parameter logic [23:0] KEY_COLOR   = 24'hFF00FF
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_pulse,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [9:0]  MarioX,
   input  logic [9:0]  MarioY,
   input  logic        walking,
   input  logic        facing_left,
   output logic [10:0] rom_addr,
   input  logic [23:0] rom_data,
   output logic [23:0] pixel_out,
   output logic        pixel_on,
   output logic [2:0]  frame_idx
);

   localparam int OFS_W  = $clog2(SPRITE_W);
   localparam int DY_W   = $clog2(SPRITE_H);
   localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

   localparam logic [OFS_W-1:0]  COL_MAX    = OFS_W'(SPRITE_W - 1);
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
   localparam logic [2:0]        FRAME_LAST = 3'(NUM_FRAMES - 1);

   localparam logic [0:0] ST_STAND = 1'b0;
   localparam logic [0:0] ST_WALK  = 1'b1;

   logic [10:0]       w_x_end_p0;
   logic [10:0]       w_y_end_p0;
   logic              w_hit_p0;
   logic [OFS_W-1:0]  w_dx_p0;
   logic [OFS_W-1:0]  w_col_p0;
   logic [DY_W-1:0]   w_dy_p0;
   logic [10:0]       w_addr_p0;

   logic [10:0]       r_rom_addr_p1;
   logic              r_hit_p1;
   logic              r_hit_p2;
   logic [23:0]       r_pixel_p3;
   logic              r_on_p3;

   logic [0:0]        r_state;
   logic [TICK_W-1:0] r_tick;
   logic [2:0]        r_frame_idx;

   // Stage 0: hit test widened to 11 bits so sprites at the far edge never wrap
   assign w_x_end_p0 = {1'b0, MarioX} + 11'(SPRITE_W);
   assign w_y_end_p0 = {1'b0, MarioY} + 11'(SPRITE_H);
   assign w_hit_p0   = (DrawX >= MarioX) && ({1'b0, DrawX} < w_x_end_p0) &&
                       (DrawY >= MarioY) && ({1'b0, DrawY} < w_y_end_p0);

   assign w_dx_p0   = OFS_W'(DrawX) - OFS_W'(MarioX);
   assign w_dy_p0   = DY_W'(DrawY) - DY_W'(MarioY);
   assign w_col_p0  = facing_left ? (COL_MAX - w_dx_p0) : w_dx_p0;
   assign w_addr_p0 = 11'(r_frame_idx) * 11'(SPRITE_W * SPRITE_H) +
                      11'(w_dy_p0) * 11'(SPRITE_W) + 11'(w_col_p0);

   // Stage 1 (address to ROM), stage 2 (ROM latency), stage 3 (colour out)
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_rom_addr_p1 <= '0;
         r_hit_p1      <= 1'b0;
         r_hit_p2      <= 1'b0;
         r_pixel_p3    <= '0;
         r_on_p3       <= 1'b0;
      end else begin
         if (w_hit_p0)
            r_rom_addr_p1 <= w_addr_p0;
         r_hit_p1   <= w_hit_p0;
         r_hit_p2   <= r_hit_p1;
         r_on_p3    <= r_hit_p2 && (rom_data != KEY_COLOR);
         r_pixel_p3 <= r_hit_p2 ? rom_data : 24'h0;
      end
   end

   // Animation only moves on frame_pulse, so a frame never changes mid-scan
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= ST_STAND;
         r_tick      <= '0;
         r_frame_idx <= 3'd0;
      end else if (frame_pulse) begin
         case (r_state)
            ST_STAND: begin
               r_tick <= '0;
               if (walking) begin
                  r_state     <= ST_WALK;
                  r_frame_idx <= 3'd1;
               end else begin
                  r_frame_idx <= 3'd0;
               end
            end
            ST_WALK: begin
               if (!walking) begin
                  r_state     <= ST_STAND;
                  r_frame_idx <= 3'd0;
                  r_tick      <= '0;
               end else if (r_tick == TICK_LAST) begin
                  r_tick      <= '0;
                  r_frame_idx <= (r_frame_idx == FRAME_LAST) ? 3'd1 : r_frame_idx + 3'd1;
               end else begin
                  r_tick <= r_tick + TICK_W'(1);
               end
            end
            default: begin
               r_state     <= ST_STAND;
               r_frame_idx <= 3'd0;
               r_tick      <= '0;
            end
         endcase
      end
   end

   assign rom_addr  = r_rom_addr_p1;
   assign pixel_out = r_pixel_p3;
   assign pixel_on  = r_on_p3;
   assign frame_idx = r_frame_idx;

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Bench for mario_sprite_fetch: behavioural ROM plus a pixel/animation reference model.
module tb_mario_sprite_fetch;

   localparam logic [23:0] KEY = 24'hFF00FF;
   localparam int FT = 6;
   localparam int NWALK = 4;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        frame_pulse;
   logic [9:0]  DrawX, DrawY, MarioX, MarioY;
   logic        walking, facing_left;
   logic [10:0] rom_addr;
   logic [23:0] rom_data;
   logic [23:0] pixel_out;
   logic        pixel_on;
   logic [2:0]  frame_idx;

   logic [23:0] mem [0:2047];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int          m_cnt;
   logic [2:0]  m_frame;
   logic [10:0] m_addr;
   bit          q_hit1, q_hit2;
   logic [10:0] q_addr2;
   logic [23:0] m_pix;
   bit          m_on;

   always #5 Clk = ~Clk;

   always @(posedge Clk) rom_data <= mem[rom_addr];

   mario_sprite_fetch dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_pulse(frame_pulse),
      .DrawX(DrawX), .DrawY(DrawY), .MarioX(MarioX), .MarioY(MarioY),
      .walking(walking), .facing_left(facing_left), .rom_addr(rom_addr),
      .rom_data(rom_data), .pixel_out(pixel_out), .pixel_on(pixel_on),
      .frame_idx(frame_idx)
   );

   // frame index as a function of consecutive walking pulses
   function automatic logic [2:0] frame_of(input int cnt);
      if (cnt == 0) return 3'd0;
      return 3'(1 + ((cnt - 1) / FT) % NWALK);
   endfunction

   task automatic model_reset;
      m_cnt = 0; m_frame = 3'd0; m_addr = '0;
      q_hit1 = 0; q_hit2 = 0; q_addr2 = '0; m_pix = '0; m_on = 0;
   endtask

   // drive one pixel, advance one clock, update the model, settle 1 ns past the edge
   task automatic cycle(input bit fp, input bit wk, input int x, input int y,
                        input int mx, input int my, input bit fl);
      int dx, dy, addr;
      bit hit;
      frame_pulse = fp; walking = wk; facing_left = fl;
      DrawX = 10'(x); DrawY = 10'(y); MarioX = 10'(mx); MarioY = 10'(my);
      dx = x - mx; dy = y - my;
      hit = (x >= mx) && (x < mx + 16) && (y >= my) && (y < my + 16);
      addr = int'(m_frame) * 256 + dy * 16 + (fl ? 15 - dx : dx);
      @(posedge Clk);
      m_pix = q_hit2 ? mem[q_addr2] : 24'h0;
      m_on  = q_hit2 && (mem[q_addr2] != KEY);
      q_hit2 = q_hit1; q_addr2 = m_addr; q_hit1 = hit;
      if (hit) m_addr = 11'(addr);
      if (fp) begin
         m_cnt = wk ? m_cnt + 1 : 0;
         m_frame = frame_of(m_cnt);
      end
      #1;
   endtask

   task automatic test_reset;
      Reset_n = 1'b0; frame_pulse = 0; walking = 0; facing_left = 0;
      DrawX = 0; DrawY = 0; MarioX = 0; MarioY = 0;
      model_reset();
      repeat (3) @(posedge Clk);
      #1;
      n_tests++; if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
      n_tests++; if (pixel_out !== 24'd0) begin n_fail++; $display("FAIL reset_pix: got %h expected 0", pixel_out); end
      n_tests++; if (pixel_on !== 1'b0) begin n_fail++; $display("FAIL reset_on: got %b expected 0", pixel_on); end
      n_tests++; if (frame_idx !== 3'd0) begin n_fail++; $display("FAIL reset_frame: got %0d expected 0", frame_idx); end
      #2 Reset_n = 1'b1;
      cycle(0, 0, 0, 0, 100, 200, 0);
      n_tests++; if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL post_reset_addr: got %0d expected 0", rom_addr); end
   endtask

   task automatic test_standing;
      cycle(1, 0, 0, 0, 100, 200, 0);
      cycle(0, 0, 103, 205, 100, 200, 0);
      n_tests++; if (rom_addr !== 11'd83) begin n_fail++; $display("FAIL stand_addr: got %0d expected 83", rom_addr); end
      cycle(0, 0, 0, 0, 100, 200, 0);
      cycle(0, 0, 0, 0, 100, 200, 0);
      n_tests++; if (pixel_out !== mem[83]) begin n_fail++; $display("FAIL stand_pix: got %h expected %h", pixel_out, mem[83]); end
      n_tests++; if (pixel_on !== 1'b1) begin n_fail++; $display("FAIL stand_on: got %b expected 1", pixel_on); end
   endtask

   task automatic test_mirror;
      cycle(0, 0, 103, 205, 100, 200, 1);
      n_tests++; if (rom_addr !== 11'd92) begin n_fail++; $display("FAIL mirror_addr: got %0d expected 92", rom_addr); end
      cycle(0, 0, 0, 0, 100, 200, 1);
      cycle(0, 0, 0, 0, 100, 200, 1);
      n_tests++; if (pixel_out !== mem[92]) begin n_fail++; $display("FAIL mirror_pix: got %h expected %h", pixel_out, mem[92]); end
   endtask

   task automatic test_transparency;
      cycle(0, 0, 104, 205, 100, 200, 0);
      n_tests++; if (rom_addr !== 11'd84) begin n_fail++; $display("FAIL key_addr: got %0d expected 84", rom_addr); end
      cycle(0, 0, 50, 50, 100, 200, 0);
      cycle(0, 0, 50, 50, 100, 200, 0);
      n_tests++; if (pixel_on !== 1'b0) begin n_fail++; $display("FAIL key_on: got %b expected 0", pixel_on); end
      cycle(0, 0, 50, 50, 100, 200, 0);
      n_tests++; if (pixel_out !== 24'h0) begin n_fail++; $display("FAIL outside_pix: got %h expected 0", pixel_out); end
      n_tests++; if (rom_addr !== 11'd84) begin n_fail++; $display("FAIL hold_addr: got %0d expected 84", rom_addr); end
   endtask

   task automatic test_walk_cycle;
      logic [2:0] want;
      cycle(1, 0, 0, 0, 100, 200, 0);
      for (int k = 1; k <= 25; k++) begin
         cycle(1, 1, 0, 0, 100, 200, 0);
         n_tests++; if (frame_idx !== m_frame) begin n_fail++; $display("FAIL walk_frame pulse %0d: got %0d expected %0d", k, frame_idx, m_frame); end
         if (k == 1 || k == 7 || k == 13 || k == 19 || k == 25) begin
            want = (k == 1) ? 3'd1 : (k == 7) ? 3'd2 : (k == 13) ? 3'd3 : (k == 19) ? 3'd4 : 3'd1;
            n_tests++; if (frame_idx !== want) begin n_fail++; $display("FAIL walk_step pulse %0d: got %0d expected %0d", k, frame_idx, want); end
         end
         cycle(0, 1, 0, 0, 100, 200, 0);
      end
      cycle(0, 0, 0, 0, 100, 200, 0);
      n_tests++; if (frame_idx !== 3'd1) begin n_fail++; $display("FAIL midframe_walk: got %0d expected 1", frame_idx); end
      cycle(1, 0, 0, 0, 100, 200, 0);
      n_tests++; if (frame_idx !== 3'd0) begin n_fail++; $display("FAIL walk_stop: got %0d expected 0", frame_idx); end
   endtask

   task automatic test_frame_timing;
      cycle(1, 1, 103, 205, 100, 200, 0);
      n_tests++; if (rom_addr !== 11'd83) begin n_fail++; $display("FAIL pulse_cycle_addr: got %0d expected 83", rom_addr); end
      cycle(0, 1, 103, 205, 100, 200, 0);
      n_tests++; if (rom_addr !== 11'd339) begin n_fail++; $display("FAIL next_frame_addr: got %0d expected 339", rom_addr); end
      cycle(1, 0, 0, 0, 100, 200, 0);
   endtask

   task automatic test_right_edge;
      cycle(0, 0, 639, 200, 630, 200, 0);
      n_tests++; if (rom_addr !== 11'd9) begin n_fail++; $display("FAIL edge_addr: got %0d expected 9", rom_addr); end
      cycle(0, 0, 5, 200, 630, 200, 0);
      cycle(0, 0, 1020, 200, 1015, 200, 0);
      n_tests++; if (pixel_out !== mem[9]) begin n_fail++; $display("FAIL edge_pix: got %h expected %h", pixel_out, mem[9]); end
      n_tests++; if (rom_addr !== 11'd5) begin n_fail++; $display("FAIL wide_addr: got %0d expected 5", rom_addr); end
      cycle(0, 0, 3, 200, 1015, 200, 0);
      n_tests++; if (pixel_on !== 1'b0) begin n_fail++; $display("FAIL edge_nowrap_on: got %b expected 0", pixel_on); end
      n_tests++; if (rom_addr !== 11'd5) begin n_fail++; $display("FAIL wide_hold: got %0d expected 5", rom_addr); end
      cycle(0, 0, 0, 0, 100, 200, 0);
      n_tests++; if (pixel_out !== mem[5]) begin n_fail++; $display("FAIL wide_pix: got %h expected %h", pixel_out, mem[5]); end
      cycle(0, 0, 0, 0, 100, 200, 0);
      n_tests++; if (pixel_on !== 1'b0) begin n_fail++; $display("FAIL wide_nowrap_on: got %b expected 0", pixel_on); end
   endtask

   task automatic test_back_to_back;
      for (int k = 1; k <= 7; k++) begin
         cycle(1, 1, 0, 0, 100, 200, 0);
         if (k == 6) begin
            n_tests++; if (frame_idx !== 3'd1) begin n_fail++; $display("FAIL b2b_pulse6: got %0d expected 1", frame_idx); end
         end
      end
      n_tests++; if (frame_idx !== 3'd2) begin n_fail++; $display("FAIL b2b_pulse7: got %0d expected 2", frame_idx); end
      cycle(1, 0, 0, 0, 100, 200, 0);
   endtask

   task automatic test_random;
      int mx, my, x, y, errs;
      bit wk;
      errs = 0; wk = 0;
      for (int c = 0; c < 800; c++) begin
         if ((c % 40) == 0) begin
            mx = int'($urandom_range(0, 1023));
            my = int'($urandom_range(0, 1023));
         end
         if ($urandom_range(0, 9) == 0) wk = ~wk;
         x = (mx + int'($urandom_range(0, 24)) - 4) & 1023;
         y = (my + int'($urandom_range(0, 20)) - 2) & 1023;
         cycle($urandom_range(0, 3) == 0, wk, x, y, mx, my, $urandom_range(0, 1) == 1);
         n_tests++;
         if (rom_addr !== m_addr || pixel_out !== m_pix || pixel_on !== m_on || frame_idx !== m_frame) begin
            n_fail++;
            if (errs < 10)
               $display("FAIL rand cyc %0d: got addr=%0d pix=%h on=%b frame=%0d expected addr=%0d pix=%h on=%b frame=%0d",
                        c, rom_addr, pixel_out, pixel_on, frame_idx, m_addr, m_pix, m_on, m_frame);
            errs++;
         end
      end
      cycle(1, 0, 0, 0, 100, 200, 0);
   endtask

   task automatic test_reset_mid;
      for (int k = 0; k < 13; k++) cycle(1, 1, 0, 0, 100, 200, 0);
      n_tests++; if (frame_idx !== 3'd3) begin n_fail++; $display("FAIL pre_reset_frame: got %0d expected 3", frame_idx); end
      cycle(0, 1, 103, 205, 100, 200, 0);
      #2 Reset_n = 1'b0;
      #1;
      n_tests++; if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL async_addr: got %0d expected 0", rom_addr); end
      n_tests++; if (pixel_out !== 24'd0 || pixel_on !== 1'b0) begin n_fail++; $display("FAIL async_pix: got %h/%b expected 0/0", pixel_out, pixel_on); end
      n_tests++; if (frame_idx !== 3'd0) begin n_fail++; $display("FAIL async_frame: got %0d expected 0", frame_idx); end
      model_reset();
      frame_pulse = 0; walking = 0;
      repeat (2) @(posedge Clk);
      #3 Reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 0, 0, 100, 200, 0);
         n_tests++; if (pixel_on !== 1'b0 || pixel_out !== 24'd0) begin n_fail++; $display("FAIL flushed_pix %0d: got %h/%b expected 0/0", k, pixel_out, pixel_on); end
      end
      cycle(1, 1, 0, 0, 100, 200, 0);
      n_tests++; if (frame_idx !== 3'd1) begin n_fail++; $display("FAIL restart_stand: got %0d expected 1", frame_idx); end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++)
         mem[i] = ($urandom_range(0, 7) == 0) ? KEY : (24'($urandom) & 24'hFFFF00);
      mem[83] = 24'h123456; mem[92] = 24'h00ABCD; mem[84] = KEY;
      mem[5]  = 24'h0F0F0F; mem[9]  = 24'h998877;
      test_reset();
      test_standing();
      test_mirror();
      test_transparency();
      test_walk_cycle();
      test_frame_timing();
      test_right_edge();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
